timer_device: RTL and testbench

TIMER_DEVICE -- requirements
Module: timer_device

---
 rtl/timer_pkg.sv | 33 +++
 rtl/timer_device.sv | 139 +++++++++++++
 tb/tb_timer_device.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Definitions shared by timer_device and the system bridge that decodes its
// window: FSM state encoding, register word offsets (Addr[3:2]), CTRL mode
// values and the packed layout of the CTRL register.
// No ports (package).
// -----------------------------------------------------------------------------
package timer_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_CNT  = 2'd2;
    localparam logic [1:0] ST_INT  = 2'd3;

    // Register word offsets as seen on Addr[3:2]
    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;
    localparam logic [1:0] OFF_RSVD   = 2'd3;

    // CTRL.MODE values; 2'b10 and 2'b11 behave as one-shot
    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    // CTRL register layout: [3] IM, [2:1] MODE, [0] EN
    typedef struct packed {
        logic       im;
        logic [1:0] mode;
        logic       en;
    } ctrl_t;

endpackage

// File: rtl/timer_device.sv
// -----------------------------------------------------------------------------
// timer_device
// 32-bit down-counting timer with one-shot and auto-reload modes, a memory-
// mapped register file (CTRL, PRESET, COUNT) and a maskable interrupt.
//
// Ports
//   clk    in   1      single clock, all state changes on its rising edge
//   reset  in   1      asynchronous, active-low reset
//   Addr   in   [31:2] word address; only Addr[3:2] is decoded
//   WE     in   1      full-word write strobe
//   Din    in   32     write data
//   Dout   out  32     combinational read data of the addressed register
//   IRQ    out  1      interrupt request (irq_flag gated by CTRL.IM)
//
// Register map (Addr[3:2])
//   00 CTRL   {28'b0, IM, MODE[1:0], EN}  read/write
//   01 PRESET 32-bit                      read/write
//   10 COUNT  32-bit                      read-only
//   11 reserved, reads RESERVED_RDATA, writes ignored
// -----------------------------------------------------------------------------
module timer_device
    import timer_pkg::*;
#(
    parameter logic [31:0] RESERVED_RDATA = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:2] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    ctrl_t       ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic [1:0]  state;
    logic        irq_flag;

    logic        ctrl_we;
    logic        preset_we;

    // Only Addr[3:2] selects a register; the bridge has already decoded the
    // upper bits into this device's window.
    logic unused_addr;
    assign unused_addr = ^Addr[31:4];

    assign ctrl_we   = WE && (Addr[3:2] == OFF_CTRL);
    assign preset_we = WE && (Addr[3:2] == OFF_PRESET);

    // -------------------------------------------------------------------------
    // Register file and FSM
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // decision below sees the values from before this edge; where two
    // assignments target the same register in one edge, the later one wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl     <= '0;
            preset   <= '0;
            count    <= '0;
            irq_flag <= 1'b0;
            state    <= ST_IDLE;
        end else begin
            if (preset_we) begin
                preset <= Din;
            end

            case (state)
                ST_IDLE: begin
                    if (ctrl.en) begin
                        state <= ST_LOAD;
                    end
                end

                // PRESET is only sampled here, so rewriting it mid-count
                // takes effect on the next load.
                ST_LOAD: begin
                    count <= preset;
                    state <= ST_CNT;
                end

                // Expiry is detected at COUNT<=1 so that PRESET=0 behaves as
                // PRESET=1 and the counter never wraps below zero.
                ST_CNT: begin
                    if (!ctrl.en) begin
                        state <= ST_IDLE;
                    end else if (count > 32'd1) begin
                        count <= count - 32'd1;
                    end else begin
                        count    <= '0;
                        irq_flag <= 1'b1;
                        state    <= ST_INT;
                    end
                end

                ST_INT: begin
                    if (ctrl.mode == MODE_RELOAD) begin
                        irq_flag <= 1'b0;
                        state    <= ST_LOAD;
                    end else begin
                        ctrl.en <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase

            // Placed after the FSM so a CPU write to CTRL overrides the
            // one-shot EN clear (and any irq_flag update) on the same edge.
            if (ctrl_we) begin
                ctrl     <= ctrl_t'(Din[3:0]);
                irq_flag <= 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Read mux and interrupt output
    // -------------------------------------------------------------------------
    // NOTE: the combinational read mux assigns Dout a default first so no
    // path through the case leaves it unassigned (no latch).
    always_comb begin
        Dout = RESERVED_RDATA;
        case (Addr[3:2])
            OFF_CTRL:   Dout = {28'b0, ctrl};
            OFF_PRESET: Dout = preset;
            OFF_COUNT:  Dout = count;
            default:    Dout = RESERVED_RDATA;
        endcase
    end

    assign IRQ = irq_flag & ctrl.im;

endmodule

// File: tb/tb_timer_device.sv
// -----------------------------------------------------------------------------
// tb_timer_device
// Self-checking bench for timer_device. Expected COUNT/IRQ/CTRL values in the
// trial task come from closed-form timing: counting from P starts two edges
// after the enabling CTRL write, expiry is max(P,1)+2 edges after it, and
// auto-reload repeats with period max(P,1)+2.
// -----------------------------------------------------------------------------
module tb_timer_device;
    import timer_pkg::*;

    localparam logic [31:0] RSVD = 32'hC0DE_0C0C;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:2] addr = '0;
    logic        we = 1'b0;
    logic [31:0] din = '0;
    logic [31:0] dout;
    logic        irq;

    int passed = 0;
    int total  = 0;

    timer_device #(.RESERVED_RDATA(RSVD)) dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (addr),
        .WE    (we),
        .Din   (din),
        .Dout  (dout),
        .IRQ   (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance one rising edge and land 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Upper address bits are randomised: only Addr[3:2] may matter.
    task automatic rd(input logic [1:0] off, output logic [31:0] val);
        we   = 1'b0;
        addr = {28'($urandom), off};
        #1;
        val = dout;
    endtask

    // The write lands on the next rising edge.
    task automatic wr(input logic [1:0] off, input logic [31:0] data);
        addr = {28'($urandom), off};
        din  = data;
        we   = 1'b1;
        @(posedge clk);
        #1;
        we  = 1'b0;
        din = $urandom;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #2;
        reset = 1'b1;
    endtask

    task automatic check_count(input string tag, input logic [31:0] exp);
        logic [31:0] v;
        rd(OFF_COUNT, v);
        check(tag, v, exp);
    endtask

    task automatic check_ctrl(input string tag, input logic [31:0] exp);
        logic [31:0] v;
        rd(OFF_CTRL, v);
        check(tag, v, exp);
    endtask

    // Reset, program PRESET=p and CTRL={im,mode,EN=1}, then compare IRQ,
    // COUNT and CTRL after each of the next ncyc edges.
    task automatic run_trial(input int p, input logic [1:0] mode, input logic im, input int ncyc);
        int          pe;
        int          per;
        int          j;
        logic        reload;
        logic [31:0] ecnt;
        logic        eirq;
        logic        een;
        do_reset();
        wr(OFF_PRESET, 32'(p));
        wr(OFF_CTRL, {28'b0, im, mode, 1'b1});
        pe     = (p == 0) ? 1 : p;
        per    = pe + 2;
        reload = (mode == MODE_RELOAD);
        for (int k = 1; k <= ncyc; k++) begin
            tick();
            if (k < 2) begin
                ecnt = '0;
            end else begin
                j    = reload ? (k - 2) % per : (k - 2);
                ecnt = (j == 0) ? 32'(p) : ((j < pe) ? 32'(p - j) : 32'd0);
            end
            if (reload) eirq = im && (k >= 2) && (((k - 2) % per) == pe);
            else        eirq = im && ((k - 2) >= pe);
            een = reload || (k < pe + 3);
            check($sformatf("irq p=%0d m=%0d k=%0d", p, mode, k), {31'b0, irq}, {31'b0, eirq});
            check_count($sformatf("count p=%0d m=%0d k=%0d", p, mode, k), ecnt);
            check_ctrl($sformatf("ctrl p=%0d m=%0d k=%0d", p, mode, k), {28'b0, im, mode, een});
        end
    endtask

    initial begin
        logic [31:0] v;
        int          p;
        int          pe;
        logic [1:0]  mode;
        logic        im;

        // Reset state
        #1;
        check("reset irq", {31'b0, irq}, 32'd0);
        check_ctrl("reset ctrl", 32'd0);
        rd(OFF_PRESET, v); check("reset preset", v, 32'd0);
        check_count("reset count", 32'd0);
        rd(OFF_RSVD, v);   check("reset rsvd", v, RSVD);
        #2;
        reset = 1'b1;

        // No counting until EN is written
        repeat (5) tick();
        check_count("idle after reset", 32'd0);

        // One-shot P=5 with IM: IRQ after edge 7, CTRL=0x8 after edge 8
        run_trial(5, MODE_ONESHOT, 1'b1, 12);
        wr(OFF_CTRL, 32'h8);
        check("oneshot irq cleared by ctrl write", {31'b0, irq}, 32'd0);

        // Auto-reload P=3: pulses after edges 5 and 10
        run_trial(3, MODE_RELOAD, 1'b1, 16);

        // IM=0: expiry stays internal; re-arming with 0x9 raises no stale IRQ
        run_trial(2, MODE_ONESHOT, 1'b0, 8);
        wr(OFF_CTRL, 32'h9);
        check("no stale irq", {31'b0, irq}, 32'd0);
        repeat (3) tick();
        check("rearm irq k3", {31'b0, irq}, 32'd0);
        tick();
        check("rearm irq k4", {31'b0, irq}, 32'd1);

        // PRESET=0 behaves as 1; reserved offset reads parameter, ignores writes
        run_trial(0, MODE_ONESHOT, 1'b1, 6);
        rd(OFF_RSVD, v); check("rsvd read", v, RSVD);
        wr(OFF_RSVD, 32'h55);
        rd(OFF_RSVD, v);   check("rsvd after write", v, RSVD);
        rd(OFF_PRESET, v); check("preset after rsvd write", v, 32'd0);

        // Stop at COUNT=100: one more decrement on the write edge, then frozen
        do_reset();
        wr(OFF_PRESET, 32'd200);
        wr(OFF_CTRL, 32'h1);
        repeat (102) tick();
        check_count("count reaches 100", 32'd100);
        wr(OFF_CTRL, 32'h0);
        check_count("count on stop edge", 32'd99);
        repeat (3) tick();
        check_count("count frozen", 32'd99);
        wr(OFF_COUNT, 32'h55);
        check_count("count write ignored", 32'd99);
        check_ctrl("ctrl stopped", 32'd0);

        // PRESET rewrite mid-count only matters at the next load
        do_reset();
        wr(OFF_PRESET, 32'd10);
        wr(OFF_CTRL, 32'h1);
        repeat (4) tick();
        wr(OFF_PRESET, 32'd3);
        check_count("count unaffected by preset", 32'd7);
        repeat (3) tick();
        check_count("count later", 32'd4);
        repeat (6) tick();
        check_ctrl("oneshot done", 32'd0);
        wr(OFF_CTRL, 32'h1);
        repeat (2) tick();
        check_count("new preset loaded", 32'd3);

        // Same-edge conflict in INT: CPU write of CTRL wins over EN clear
        do_reset();
        wr(OFF_PRESET, 32'd1);
        wr(OFF_CTRL, 32'h9);
        repeat (3) tick();
        check("conflict irq in INT", {31'b0, irq}, 32'd1);
        wr(OFF_CTRL, 32'h9);
        check_ctrl("conflict ctrl kept", 32'h9);
        check("conflict irq cleared", {31'b0, irq}, 32'd0);
        repeat (2) tick();
        check_count("conflict reload", 32'd1);
        check("conflict irq before", {31'b0, irq}, 32'd0);
        tick();
        check("conflict irq again", {31'b0, irq}, 32'd1);

        // Asynchronous reset mid-count
        do_reset();
        wr(OFF_PRESET, 32'd50);
        wr(OFF_CTRL, 32'h9);
        repeat (12) tick();
        check_count("count at 40", 32'd40);
        reset = 1'b0;
        #1;
        check("midcount rst irq", {31'b0, irq}, 32'd0);
        check_count("midcount rst count", 32'd0);
        check_ctrl("midcount rst ctrl", 32'd0);
        rd(OFF_PRESET, v); check("midcount rst preset", v, 32'd0);
        reset = 1'b1;
        repeat (5) tick();
        check_count("no count after reset", 32'd0);

        // Asynchronous reset in INT with IRQ high
        wr(OFF_PRESET, 32'd1);
        wr(OFF_CTRL, 32'h9);
        repeat (3) tick();
        check("int irq high", {31'b0, irq}, 32'd1);
        reset = 1'b0;
        #1;
        check("int rst irq", {31'b0, irq}, 32'd0);
        check_ctrl("int rst ctrl", 32'd0);
        rd(OFF_PRESET, v); check("int rst preset", v, 32'd0);
        reset = 1'b1;

        // Randomised trials
        for (int t = 0; t < 6; t++) begin
            p    = int'($urandom_range(0, 12));
            mode = 2'($urandom_range(0, 3));
            im   = 1'($urandom_range(0, 1));
            pe   = (p == 0) ? 1 : p;
            run_trial(p, mode, im, 3 * (pe + 2) + 2);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
